// File: rtl/systolic_postproc_if.sv
// systolic_postproc_if: streaming handshake bundle between array, post-processor and sink
// Signals: valid_in/ready_out/y_in (upstream beat), q_out/valid_out/ready_in/last_out/sat_out (downstream beat)
// Modports: slave = post-processor side, master = upstream source plus downstream sink
interface systolic_postproc_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
);
    logic                      valid_in;
    logic                      ready_out;
    logic [N*ACC_WIDTH-1:0]    y_in;
    logic [N*DATA_WIDTH-1:0]   q_out;
    logic                      valid_out;
    logic                      ready_in;
    logic                      last_out;
    logic                      sat_out;
    modport master (output valid_in, y_in, ready_in, input ready_out, q_out, valid_out, last_out, sat_out);
    modport slave  (input valid_in, y_in, ready_in, output ready_out, q_out, valid_out, last_out, sat_out);
endinterface

// File: rtl/systolic_postproc.sv
// systolic_postproc: two-stage bias-add / round-shift-saturate post-processor for systolic array rows
// Ports: clk, rst_n (async active-low), bus (systolic_postproc_if.slave: beats in/out with valid/ready,
//        last_out marks tile end, sat_out flags clamping), cfg_we/cfg_bias/cfg_shift (configuration write).
// Define SYSTOLIC_POSTPROC_RELU_EN to clip negative results to zero instead of emitting signed output.
module systolic_postproc #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int TILE_ROWS  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    systolic_postproc_if.slave     bus,
    input  logic                   cfg_we,
    input  logic [N*ACC_WIDTH-1:0] cfg_bias,
    input  logic [4:0]             cfg_shift
);
    localparam int AW = ACC_WIDTH;
    localparam int SW = AW + 1;
    localparam int RW = AW + 2;
    localparam int DW = DATA_WIDTH;
    localparam int CW = TILE_ROWS > 1 ? $clog2(TILE_ROWS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TILE_ROWS - 1);
    localparam logic signed [RW-1:0] QMAX = RW'(2 ** (DW - 1) - 1);
    localparam logic signed [RW-1:0] QMIN = ~QMAX;

    logic [N*AW-1:0]        bias_r;
    logic [4:0]             shift_r;
    logic                   s1_valid;
    logic [4:0]             s1_shift;
    logic [N*SW-1:0]        s1_sum;
    logic                   s2_valid;
    logic [N*DW-1:0]        q_r;
    logic                   sat_r;
    logic [CW-1:0]          cnt;
    logic [N*SW-1:0]        sum_nxt;
    logic [N*DW-1:0]        q_nxt;
    logic                   sat_nxt;
    logic [RW-1:0]          rnd;
    logic signed [RW-1:0]   ext;
    logic signed [RW-1:0]   r;
    logic                   s2_en;

    assign s2_en         = !s2_valid || bus.ready_in;
    assign bus.ready_out = !s1_valid || s2_en;
    assign bus.valid_out = s2_valid;
    assign bus.q_out     = q_r;
    assign bus.sat_out   = sat_r;
    assign bus.last_out  = s2_valid && cnt == LAST;

    always_comb begin
        // 2^(s-1) for s>0, 0 for s=0, so one datapath covers both cases
        rnd     = (RW'(1) << s1_shift) >> 1;
        ext     = '0;
        r       = '0;
        sum_nxt = '0;
        q_nxt   = '0;
        sat_nxt = 1'b0;
        for (int j = 0; j < N; j++) begin
            sum_nxt[j*SW +: SW] = SW'(signed'(bus.y_in[j*AW +: AW])) + SW'(signed'(bias_r[j*AW +: AW]));
            ext = RW'(signed'(s1_sum[j*SW +: SW]));
            r   = (ext + signed'(rnd)) >>> s1_shift;
`ifdef SYSTOLIC_POSTPROC_RELU_EN
            r   = r[RW-1] ? '0 : r;
`endif
            q_nxt[j*DW +: DW] = r > QMAX ? QMAX[DW-1:0] : r < QMIN ? QMIN[DW-1:0] : r[DW-1:0];
            sat_nxt = sat_nxt || r > QMAX || r < QMIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_r   <= '0;
            shift_r  <= '0;
            s1_valid <= 1'b0;
            s1_shift <= '0;
            s1_sum   <= '0;
            s2_valid <= 1'b0;
            q_r      <= '0;
            sat_r    <= 1'b0;
            cnt      <= '0;
        end else begin
            if (cfg_we) begin
                bias_r  <= cfg_bias;
                shift_r <= cfg_shift;
            end
            if (bus.ready_out) begin
                s1_valid <= bus.valid_in;
                if (bus.valid_in) begin
                    s1_sum   <= sum_nxt;
                    // shift travels with the beat so a same-cycle cfg write cannot affect it in S2
                    s1_shift <= shift_r;
                end
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    q_r   <= q_nxt;
                    sat_r <= sat_nxt;
                end
            end
            if (s2_valid && bus.ready_in)
                cnt <= cnt == LAST ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_systolic_postproc.sv
// tb_systolic_postproc: directed self-checking bench for systolic_postproc (N=4, 8-bit out, 32-bit acc, 8-row tiles)
module tb_systolic_postproc;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_we = 1'b0;
    logic [N*32-1:0] cfg_bias = '0;
    logic [4:0] cfg_shift = '0;
    int compared = 0;
    int errs = 0;
    int out_cnt = 0;

    systolic_postproc_if #(.N(N), .DATA_WIDTH(8), .ACC_WIDTH(32)) bus ();

    systolic_postproc #(.N(N), .DATA_WIDTH(8), .ACC_WIDTH(32), .TILE_ROWS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cfg_we    (cfg_we),
        .cfg_bias  (cfg_bias),
        .cfg_shift (cfg_shift)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int b, input logic [4:0] s);
        cfg_we = 1'b1;
        cfg_bias = {N{32'(b)}};
        cfg_shift = s;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        bus.valid_in = 1'b0;
        cfg_we = 1'b0;
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        out_cnt = 0;
    endtask

    task automatic beat(input int v, input logic [7:0] eq, input logic es);
        bus.valid_in = 1'b1;
        bus.y_in = {N{32'(v)}};
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        chk("lat1_valid", bus.valid_out, 0);
        @(posedge clk); #1;
        chk("valid", bus.valid_out, 1);
        chk("q", bus.q_out, {N{eq}});
        chk("sat", bus.sat_out, es);
        chk("last", bus.last_out, out_cnt == 7);
        out_cnt = (out_cnt + 1) % 8;
    endtask

    initial begin
        int sent, recv;
        logic stalled;
        logic [31:0] held_q;
        logic held_last, held_sat;
        bus.valid_in = 1'b0;
        bus.y_in = '0;
        bus.ready_in = 1'b1;
        #2;
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_q", bus.q_out, 0);
        chk("rst_last", bus.last_out, 0);
        chk("rst_sat", bus.sat_out, 0);
        chk("rst_ready", bus.ready_out, 1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", bus.ready_out, 1);

        beat(5, 8'h05, 1'b0);
        cfg(3, 5'd2);
        beat(6, 8'h02, 1'b0);
        beat(-7, 8'hff, 1'b0);
        beat(-5, 8'h00, 1'b0);
        cfg(0, 5'd0);
        beat(1000, 8'h7f, 1'b1);
`ifdef SYSTOLIC_POSTPROC_RELU_EN
        beat(-1000, 8'h00, 1'b0);
        beat(127, 8'h7f, 1'b0);
        beat(-128, 8'h00, 1'b0);
`else
        beat(-1000, 8'h80, 1'b1);
        beat(127, 8'h7f, 1'b0);
        beat(-128, 8'h80, 1'b0);
`endif
        cfg(0, 5'd4);
        beat(40, 8'h03, 1'b0);
        beat(3000, 8'h7f, 1'b1);

        // config write coincident with beat A; beat B follows
        do_reset();
        cfg(7, 5'd0);
        cfg_we = 1'b1;
        cfg_bias = {N{32'd10}};
        bus.valid_in = 1'b1;
        bus.y_in = '0;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        chk("cfgA_valid", bus.valid_out, 1);
        chk("cfgA_q", bus.q_out, {N{8'h07}});
        @(posedge clk); #1;
        chk("cfgB_valid", bus.valid_out, 1);
        chk("cfgB_q", bus.q_out, {N{8'h0a}});
        chk("cfgB_last", bus.last_out, 0);
        @(posedge clk); #1;
        chk("cfg_drain", bus.valid_out, 0);

        // 20 back-to-back beats against a randomly stalling sink
        do_reset();
        sent = 0;
        recv = 0;
        stalled = 1'b0;
        held_q = '0;
        held_last = 1'b0;
        held_sat = 1'b0;
        for (int c = 0; c < 400 && recv < 20; c++) begin
            bus.valid_in = sent < 20;
            bus.y_in = {N{32'(sent + 1)}};
            bus.ready_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (stalled) begin
                chk("stall_valid", bus.valid_out, 1);
                chk("stall_q", bus.q_out, held_q);
                chk("stall_last", bus.last_out, held_last);
                chk("stall_sat", bus.sat_out, held_sat);
            end
            stalled = bus.valid_out && !bus.ready_in;
            held_q = bus.q_out;
            held_last = bus.last_out;
            held_sat = bus.sat_out;
            if (bus.valid_out && bus.ready_in) begin
                chk("stream_q", bus.q_out, {N{8'(recv + 1)}});
                chk("stream_last", bus.last_out, (recv % 8) == 7);
                recv++;
            end
            if (bus.valid_in && bus.ready_out) sent++;
            @(posedge clk); #1;
        end
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        chk("stream_recv", recv, 20);
        chk("stream_sent", sent, 20);

        // reset with two beats stalled in flight and counter mid-tile
        do_reset();
        cfg(4, 5'd0);
        beat(1, 8'h05, 1'b0);
        beat(2, 8'h06, 1'b0);
        beat(3, 8'h07, 1'b0);
        bus.valid_in = 1'b1;
        bus.y_in = {N{32'd11}};
        @(posedge clk); #1;
        bus.ready_in = 1'b0;
        bus.y_in = {N{32'd12}};
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        chk("full_valid", bus.valid_out, 1);
        chk("full_ready", bus.ready_out, 0);
        chk("full_q", bus.q_out, {N{8'h0f}});
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.valid_out, 0);
        chk("midrst_q", bus.q_out, 0);
        chk("midrst_last", bus.last_out, 0);
        chk("midrst_ready", bus.ready_out, 1);
        #2 rst_n = 1'b1;
        bus.ready_in = 1'b1;
        out_cnt = 0;
        @(posedge clk); #1;
        chk("discard_valid", bus.valid_out, 0);
        @(posedge clk); #1;
        chk("discard_valid2", bus.valid_out, 0);
        for (int i = 0; i < 8; i++) beat(9, 8'h09, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errs);
        $finish;
    end
endmodule
